// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host-side initiator.
package wb_host_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int unsigned RSP_ERR_DATA   = 0;
  localparam int          DEF_ADR_W      = 32;
  localparam int          DEF_DAT_W      = 32;
  localparam int          DEF_TIMEOUT    = 255;
endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating bus-cycle counter; flags the last permitted cycle before abort.
module wb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_in;
      assign unused_in = en ^ clr;
      assign expired   = 1'b0;
    end else begin : g_on
      logic [CW-1:0] cnt;
      always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i)                    cnt <= '0;
        else if (clr)                    cnt <= '0;
        else if (en && (cnt != {CW{1'b1}})) cnt <= cnt + 1'b1;
      end
      // Counter holds k-1 during the k-th bus cycle, so this fires on cycle TIMEOUT_CYCLES.
      assign expired = (cnt == CW'(TIMEOUT_CYCLES - 1));
    end
  endgenerate
endmodule

// File: rtl/wb_host_master.sv
// Valid/ready command stream to Wishbone classic single transfers, with ack timeout.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
  parameter int ADR_W          = DEF_ADR_W,
  parameter int DAT_W          = DEF_DAT_W
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [ADR_W-1:0]   cmd_adr,
  input  logic [DAT_W-1:0]   cmd_dat,
  input  logic [DAT_W/8-1:0] cmd_sel,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DAT_W-1:0]   rsp_dat,
  output logic               rsp_err,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [DAT_W/8-1:0] wbm_sel_o,
  output logic [ADR_W-1:0]   wbm_adr_o,
  output logic [DAT_W-1:0]   wbm_dat_o,
  input  logic [DAT_W-1:0]   wbm_dat_i,
  input  logic               wbm_ack_i
);
  state_t state;
  logic   expired;
  logic   rsp_done;

  assign cmd_ready = (state == IDLE);
  assign rsp_done  = (state == RESP) && rsp_ready;

  wb_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .en       (state == BUS),
    .clr      (rsp_done),
    .expired  (expired)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          wbm_we_o  <= cmd_we;
          wbm_adr_o <= cmd_adr;
          wbm_dat_o <= cmd_dat;
          wbm_sel_o <= cmd_sel;
          wbm_cyc_o <= 1'b1;
          wbm_stb_o <= 1'b1;
          state     <= BUS;
        end
        BUS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (wbm_ack_i) begin
            rsp_dat   <= wbm_we_o ? '0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= RESP;
          end else if (expired) begin
            rsp_dat   <= DAT_W'(RSP_ERR_DATA);
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_host_master.sv
// Randomized scoreboard bench for wb_host_master with a behavioural Wishbone slave.
module tb_wb_host_master;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, dato, dati;
  logic        ack;

  always #5 clk = ~clk;

  wb_host_master #(.TIMEOUT_CYCLES(T), .ADR_W(32), .DAT_W(32)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
    .wbm_adr_o(adr), .wbm_dat_o(dato), .wbm_dat_i(dati), .wbm_ack_i(ack)
  );

  // delay = bus cycle (1-based) in which the slave acks; 0 = never acks
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          delay;
    logic [31:0] rdata;
  } txn_t;
  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  txn_t plan[$];
  rsp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   slave_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit acked(input txn_t t);
    return (t.delay != 0) && (t.delay <= T);
  endfunction

  // Present a command and wait until it is taken; leaves cmd_valid high.
  task automatic accept(input txn_t t);
    int w = 0;
    cmd_valid = 1'b1;
    cmd_we = t.we; cmd_adr = t.adr; cmd_dat = t.dat; cmd_sel = t.sel;
    while (!cmd_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got no cmd_ready within %0d cycles", w);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input txn_t t);
    rsp_t r;
    r.dat = acked(t) ? (t.we ? 32'h0 : t.rdata) : 32'h0;
    r.err = !acked(t);
    plan.push_back(t);
    expq.push_back(r);
    accept(t);
  endtask

  function automatic txn_t mk(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int dl, input logic [31:0] rd);
    txn_t t;
    t.we = w; t.adr = a; t.dat = d; t.sel = s; t.delay = dl; t.rdata = rd;
    return t;
  endfunction

  // Wishbone slave: follows the plan, checks bus fields and cycle length.
  initial begin
    txn_t cur;
    bit   active = 1'b0;
    int   n = 0;
    ack = 1'b0; dati = '0;
    cur = mk(0, 0, 0, 0, 0, 0);
    forever begin
      @(negedge clk);
      if (!slave_en || rst) begin
        ack = 1'b0;
        active = 1'b0;
      end else if (cyc) begin
        if (!active) begin
          if (plan.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_cycle: got cyc=1 expected no bus cycle");
            cur = mk(0, 0, 0, 0, 0, 0);
          end else cur = plan.pop_front();
          active = 1'b1;
          n = 0;
        end
        n++;
        chk("stb", {31'b0, stb}, 32'd1);
        chk("wbm_we", {31'b0, we}, {31'b0, cur.we});
        chk("wbm_adr", adr, cur.adr);
        chk("wbm_dat", dato, cur.dat);
        chk("wbm_sel", {28'b0, sel}, {28'b0, cur.sel});
        ack  = (cur.delay != 0) && (n == cur.delay);
        dati = ack ? cur.rdata : $urandom;
      end else begin
        if (active) begin
          chk("cyc_len", n, acked(cur) ? cur.delay : T);
          active = 1'b0;
        end
        chk("stb_low", {31'b0, stb}, 32'd0);
        // stray acks outside a bus cycle must be ignored
        ack  = ($urandom_range(0, 3) == 0);
        dati = $urandom;
      end
    end
  end

  // Response monitor: drives rsp_ready, checks stability and pops the scoreboard.
  initial begin
    bit          seen = 1'b0;
    bit          retain = 1'b0;
    int          hold = 0;
    int          idx = 0;
    logic [31:0] pd = '0;
    logic        pe = 1'b0;
    rsp_t        e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0; retain = 1'b0;
      end else begin
        if (retain) begin
          chk("rsp_dat_retain", rsp_dat, pd);
          chk("rsp_err_clear", {31'b0, rsp_err}, 32'd0);
          chk("rsp_valid_clear", {31'b0, rsp_valid}, 32'd0);
          retain = 1'b0;
        end
        if (rsp_valid) begin
          chk("cmd_ready_in_resp", {31'b0, cmd_ready}, 32'd0);
          if (!seen) begin
            seen = 1'b1;
            hold = (idx < 2) ? 5 : $urandom_range(0, 3);
          end else begin
            chk("rsp_dat_stable", rsp_dat, pd);
            chk("rsp_err_stable", {31'b0, rsp_err}, {31'b0, pe});
          end
          pd = rsp_dat; pe = rsp_err;
          rsp_ready = (hold == 0);
          if (hold > 0) hold--;
          if (rsp_ready) begin
            if (expq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_rsp: got dat=%0h err=%0b expected none", rsp_dat, rsp_err);
            end else begin
              e = expq.pop_front();
              chk("rsp_dat", rsp_dat, e.dat);
              chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            end
            idx++;
            seen = 1'b0;
            retain = 1'b1;
          end
        end else begin
          rsp_ready = $urandom_range(0, 1);
        end
      end
    end
  end

  initial begin
    int w;
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("rst_cyc", {31'b0, cyc}, 32'd0);
    chk("rst_stb", {31'b0, stb}, 32'd0);
    chk("rst_we", {31'b0, we}, 32'd0);
    chk("rst_sel", {28'b0, sel}, 32'd0);
    chk("rst_adr", adr, 32'd0);
    chk("rst_dat", dato, 32'd0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    chk("rst_rsp_dat", rsp_dat, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed: write, single-cycle read, timeout, recovery, ack on the timeout cycle
    send(mk(1'b1, 32'h3000_0004, 32'hCAFE_F00D, 4'hF, 3, 32'hDEAD_BEEF));
    send(mk(1'b0, 32'h3000_0000, 32'h1111_2222, 4'hF, 1, 32'h1234_5678));
    send(mk(1'b0, 32'h3000_0008, 32'h0, 4'h3, 0, 32'h5555_5555));
    send(mk(1'b1, 32'h3000_000C, 32'h0BAD_F00D, 4'h1, 2, 32'h0));
    send(mk(1'b0, 32'h3000_0010, 32'h0, 4'hF, T, 32'hA5A5_5A5A));
    send(mk(1'b0, 32'h3000_0014, 32'h0, 4'hF, T + 1, 32'h7777_7777));

    for (int i = 0; i < 40; i++)
      send(mk($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom,
              4'($urandom_range(1, 15)), $urandom_range(0, T + 2), $urandom));
    cmd_valid = 1'b0;

    w = 0;
    while ((expq.size() != 0 || cyc || rsp_valid) && w < 500) begin
      @(negedge clk);
      w++;
    end
    chk("drain_pending", expq.size(), 0);

    // asynchronous reset in the middle of a bus cycle
    slave_en = 1'b0;
    @(negedge clk);
    accept(mk(1'b1, 32'h3000_0020, 32'hFEED_FACE, 4'hF, 0, 32'h0));
    cmd_valid = 1'b0;
    chk("cyc_before_rst", {31'b0, cyc}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_cyc", {31'b0, cyc}, 32'd0);
    chk("async_rst_stb", {31'b0, stb}, 32'd0);
    chk("async_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("async_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_rst_cyc", {31'b0, cyc}, 32'd0);
    chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    slave_en = 1'b1;
    @(negedge clk);

    send(mk(1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 32'h0F0F_0F0F));
    cmd_valid = 1'b0;
    w = 0;
    while ((expq.size() != 0 || cyc || rsp_valid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("final_drain", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
